pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/adder_pkg.sv | 14 +
 rtl/adder_segment.sv | 20 ++
 rtl/pipelined_adder.sv | 143 ++++++++++++++
 tb/tb_pipelined_adder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
package adder_pkg;

  localparam int unsigned DEFAULT_SIZE   = 32;
  localparam int unsigned DEFAULT_STAGES = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int unsigned seg_width(input int unsigned size, input int unsigned stages);
    return size / stages;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// Combinational W-bit adder slice; cmsb is the carry into the slice's top bit.
module adder_segment #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] sum;

  assign sum  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  assign s    = sum[W-1:0];
  assign cout = sum[W];
  assign cmsb = a[W-1] ^ b[W-1] ^ sum[W-1];

endmodule

// File: rtl/pipelined_adder.sv
// Carry-registered pipelined adder/subtractor, one W-bit segment per stage.
// Define PIPELINED_ADDER_FLAGS_EN to enable the Ovf and Zero flag outputs.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int unsigned SIZE   = DEFAULT_SIZE,
  parameter int unsigned STAGES = DEFAULT_STAGES
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [SIZE-1:0] X,
  input  logic [SIZE-1:0] Y,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] S,
  output logic            Cout,
  output logic            Ovf,
  output logic            Zero
);

  localparam int unsigned W = seg_width(SIZE, STAGES);

  if (STAGES < 1 || STAGES > SIZE || (SIZE % STAGES) != 0) begin : g_bad_cfg
    $error("pipelined_adder: SIZE must be a multiple of STAGES, 1 <= STAGES <= SIZE");
  end

  // Single advance enable: the whole pipeline moves or holds together.
  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

`ifdef PIPELINED_ADDER_FLAGS_EN
  logic ovf_d;
  logic ovf_q;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned HI = SIZE - k * W;

    logic [HI-1:0]        a_in;
    logic [HI-1:0]        b_in;
    logic                 cin;
    logic                 v_in;
    logic [(k+1)*W-1:0]   s_in;
    logic [W-1:0]         seg_s;
    logic                 seg_cout;
    logic                 seg_cmsb;
    logic                 v_q;
    logic                 c_q;
    logic [(k+1)*W-1:0]   s_q;

    if (k == 0) begin : g_first
      // Bubbles carry zero operands so nothing stale follows them down the pipe.
      assign v_in = in_valid;
      assign a_in = in_valid ? X : '0;
      assign b_in = !in_valid ? '0 : ((sub == OP_SUB) ? ~Y : Y);
      assign cin  = in_valid && (sub == OP_SUB);
      assign s_in = seg_s;
    end else begin : g_next
      assign v_in = g_stage[k-1].v_q;
      assign a_in = g_stage[k-1].g_ops.a_q;
      assign b_in = g_stage[k-1].g_ops.b_q;
      assign cin  = g_stage[k-1].c_q;
      assign s_in = {seg_s, g_stage[k-1].s_q};
    end

    adder_segment #(
      .W(W)
    ) u_seg (
      .a   (a_in[W-1:0]),
      .b   (b_in[W-1:0]),
      .cin (cin),
      .s   (seg_s),
      .cout(seg_cout),
      .cmsb(seg_cmsb)
    );

    always_ff @(posedge clk) begin
      if (reset) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= seg_cout;
        s_q <= s_in;
      end
    end

    // Only the not-yet-added high operand bits travel on to later stages.
    if (k < STAGES - 1) begin : g_ops
      logic [HI-W-1:0] a_q;
      logic [HI-W-1:0] b_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[HI-1:W];
          b_q <= b_in[HI-1:W];
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
`ifdef PIPELINED_ADDER_FLAGS_EN
      assign ovf_d = seg_cmsb ^ seg_cout;
`else
      logic unused_cmsb;
      assign unused_cmsb = seg_cmsb;
`endif
    end else begin : g_mid
      logic unused_cmsb;
      assign unused_cmsb = seg_cmsb;
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign S         = g_stage[STAGES-1].s_q;
  assign Cout      = g_stage[STAGES-1].c_q;

`ifdef PIPELINED_ADDER_FLAGS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= ovf_d;
    end
  end

  assign Ovf  = ovf_q;
  // Qualified by out_valid so the cleared result after reset does not read as zero.
  assign Zero = out_valid && (S == '0);
`else
  assign Ovf  = 1'b0;
  assign Zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (SIZE=32, STAGES=4), with an arithmetic reference model.
module tb_pipelined_adder;

`ifdef PIPELINED_ADDER_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] X;
  logic [31:0] Y;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        Cout;
  logic        Ovf;
  logic        Zero;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipelined_adder #(
    .SIZE  (32),
    .STAGES(4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .X        (X),
    .Y        (Y),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .S        (S),
    .Cout     (Cout),
    .Ovf      (Ovf),
    .Zero     (Zero)
  );

  // Reference: plain unsigned/signed arithmetic, packed as {S, Cout, Ovf, Zero}.
  function automatic logic [34:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic sb);
    logic [31:0] s;
    logic        c;
    logic        o;
    longint      r;
    longint      lim;
    lim = 64'sd2147483648;
    if (sb) begin
      s = x - y;
      c = (x >= y);
      r = longint'($signed(x)) - longint'($signed(y));
    end else begin
      s = x + y;
      c = (({1'b0, x} + {1'b0, y}) > 33'h0_FFFF_FFFF);
      r = longint'($signed(x)) + longint'($signed(y));
    end
    o = (r >= lim) || (r < -lim);
    return {s, c, FLAGS & o, FLAGS & (s == 32'd0)};
  endfunction

  // Issue one op into an idle pipeline and wait for its result; lat counts edges.
  task automatic issue_and_wait(input logic [31:0] x, input logic [31:0] y, input logic sb,
                                output int lat);
    @(posedge clk); #1;
    X = x; Y = y; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; X = $urandom; Y = $urandom; sub = 1'($urandom_range(0, 1));
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; X = '0; Y = '0; sub = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, S, Cout, Ovf, Zero, in_ready} !== {1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset: got valid=%b S=%h C=%b O=%b Z=%b rdy=%b want 0 0 0 0 0 1",
               out_valid, S, Cout, Ovf, Zero, in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_add_wrap();
    int lat;
    issue_and_wait(32'hFFFF_FFFF, 32'd1, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL add_wrap latency: got %0d want 4", lat);
    end
    checks++;
    if ({S, Cout, Ovf, Zero} !== {32'd0, 1'b1, 1'b0, FLAGS}) begin
      errors++;
      $display("FAIL add_wrap: got S=%h C=%b O=%b Z=%b want S=0 C=1 O=0 Z=%b",
               S, Cout, Ovf, Zero, FLAGS);
    end
  endtask

  task automatic test_sub_ovf();
    int lat;
    issue_and_wait(32'd5, 32'd7, 1'b1, lat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL sub latency: got %0d want 4", lat);
    end
    checks++;
    if ({S, Cout, Ovf, Zero} !== {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_5_7: got S=%h C=%b O=%b Z=%b want S=fffffffe C=0 O=0 Z=0",
               S, Cout, Ovf, Zero);
    end
    issue_and_wait(32'h7FFF_FFFF, 32'd1, 1'b0, lat);
    checks++;
    if ({S, Cout, Ovf, Zero} !== {32'h8000_0000, 1'b0, FLAGS, 1'b0}) begin
      errors++;
      $display("FAIL add_ovf: got S=%h C=%b O=%b Z=%b want S=80000000 C=0 O=%b Z=0",
               S, Cout, Ovf, Zero, FLAGS);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got[$];
    logic [31:0] held_s;
    int          sent = 0;
    int          stall_left = 0;
    bit          stall_done = 1'b0;
    bit          held = 1'b0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 60 && got.size() < 6; cyc++) begin
      if (out_valid && !stall_done) begin
        stall_done = 1'b1;
        stall_left = 3;
      end
      out_ready = (stall_left == 0);
      in_valid  = (sent < 6);
      X = 32'(sent); Y = 32'd1; sub = 1'b0;
      @(negedge clk);
      if (stall_left > 0) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++; $display("FAIL stall in_ready: got %b want 0", in_ready);
        end
        if (held) begin
          checks++;
          if (S !== held_s) begin
            errors++; $display("FAIL stall hold S: got %h want %h", S, held_s);
          end
        end
        held = 1'b1; held_s = S;
        stall_left--;
      end
      if (out_valid && out_ready) got.push_back(S);
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (got.size() != 6) begin
      errors++; $display("FAIL b2b count: got %0d want 6", got.size());
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 32'(i + 1)) begin
        errors++; $display("FAIL b2b order[%0d]: got %h want %h", i, got[i], 32'(i + 1));
      end
    end
  endtask

  task automatic test_reset_midflight();
    int lat;
    bit seen = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b1; X = 32'd1; Y = 32'd2; sub = 1'b0;
    @(posedge clk); #1;
    X = 32'd3; Y = 32'd4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (out_valid) seen = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    if (out_valid) seen = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    reset = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL flush: got out_valid=1 for discarded ops want 0");
    end
    issue_and_wait(32'd10, 32'd20, 1'b0, lat);
    checks++;
    if (lat !== 4) begin
      errors++; $display("FAIL post_reset latency: got %0d want 4", lat);
    end
    checks++;
    if ({S, Cout} !== {32'd30, 1'b0}) begin
      errors++; $display("FAIL post_reset sum: got S=%h C=%b want S=1e C=0", S, Cout);
    end
  endtask

  task automatic test_random();
    logic [34:0] q[$];
    logic [34:0] exp;
    logic [34:0] prev;
    bit          held = 1'b0;
    int          acc = 0;
    int          done = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc >= 300 && q.size() == 0) break;
      @(posedge clk); #1;
      in_valid  = (cyc < 300) && ($urandom_range(0, 3) != 0);
      X = $urandom; Y = $urandom; sub = 1'($urandom_range(0, 1));
      if (cyc % 5 == 0) Y = X;
      if (cyc % 7 == 0) X = 32'h7FFF_FFFF;
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (held) begin
        checks++;
        if (!out_valid || {S, Cout, Ovf, Zero} !== prev) begin
          errors++;
          $display("FAIL rand hold: got v=%b %h want v=1 %h", out_valid, {S, Cout, Ovf, Zero}, prev);
        end
      end
      held = out_valid && !out_ready;
      prev = {S, Cout, Ovf, Zero};
      if (out_valid && out_ready) begin
        checks++;
        done++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand extra result: got S=%h want none", S);
        end else begin
          exp = q.pop_front();
          if ({S, Cout, Ovf, Zero} !== exp) begin
            errors++;
            $display("FAIL rand result: got S=%h C=%b O=%b Z=%b want S=%h C=%b O=%b Z=%b",
                     S, Cout, Ovf, Zero, exp[34:3], exp[2], exp[1], exp[0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(X, Y, sub));
        acc++;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    checks++;
    if (q.size() != 0 || done != acc) begin
      errors++; $display("FAIL rand drain: got %0d results want %0d", done, acc);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add_wrap();
    test_sub_ovf();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
